// File: rtl/hann_pkg.sv
// Shared helpers for the Hann window engine: table sizing, frame-length clamp
// and half-window mirror indexing.
package hann_pkg;

  function automatic int tbl_depth(input int max_log2n);
    return (1 << (max_log2n - 1)) + 1;
  endfunction

  function automatic logic [3:0] clamp_log2n(input logic [3:0] v, input int lo, input int hi);
    if (int'(v) < lo) return 4'(lo);
    if (int'(v) > hi) return 4'(hi);
    return v;
  endfunction

  // Scale k up to the full-length grid, then fold the upper half onto the stored half.
  function automatic int mirror_idx(input int k, input int l, input int max_log2n);
    int j;
    j = k << (max_log2n - l);
    if (j > (1 << (max_log2n - 1))) j = (1 << max_log2n) - j;
    return j;
  endfunction

endpackage

// File: rtl/hann_coef_ram.sv
// Simple dual-port coefficient table: one write port, one registered read port
// (read-first on a same-address collision).
module hann_coef_ram #(
  parameter int AW        = 10,
  parameter int DW        = 16,
  parameter int DEPTH     = 513,
  parameter     INIT_FILE = "NONE"
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk)
    if (wr_en && (int'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;

  always_ff @(posedge clk)
    if (rd_en) rd_data <= mem[rd_addr];

endmodule

// File: rtl/hann_window_apply.sv
// Streaming Hann window: index/mirror stage, table read stage, multiply-round stage.
// All stages advance together on adv so a downstream stall freezes the whole pipe.
module hann_window_apply
  import hann_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int MAX_LOG2N = 10,
  parameter int MIN_LOG2N = 6,
  parameter     INIT_FILE = "NONE"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           cfg_log2n,
  input  logic                 cfg_bypass,
  input  logic                 frame_rst,
  input  logic                 coef_wr_en,
  input  logic [MAX_LOG2N-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]    coef_wr_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_last
);

  localparam int TBL_D  = tbl_depth(MAX_LOG2N);
  localparam int STAGES = 2;
  localparam int PW     = DATA_W + COEF_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) << (COEF_W - 1);

  logic [STAGES:0]        vld_pipe;
  logic                   adv, acc;

  logic [MAX_LOG2N-1:0]   k_q, k_eff, k_nxt, j_eff;
  logic [3:0]             l_q, l_eff;
  logic                   byp_q, byp_eff, start, last_eff;

  logic [DATA_W-1:0]      s1_data, s2_data;
  logic [MAX_LOG2N-1:0]   s1_j;
  logic                   s1_last, s1_byp, s2_last, s2_byp;
  logic [COEF_W-1:0]      coef;

  logic signed [PW-1:0]   prod, prod_r;
  logic [DATA_W-1:0]      wdata;

  assign m_valid = vld_pipe[STAGES];
  assign adv     = m_ready | ~vld_pipe[STAGES];
  assign s_ready = adv;
  assign acc     = s_valid & adv;

  // frame_rst coincident with an accept makes that sample index 0 (and a frame start).
  always_comb begin
    k_eff    = frame_rst ? '0 : k_q;
    start    = (k_eff == '0);
    l_eff    = start ? clamp_log2n(cfg_log2n, MIN_LOG2N, MAX_LOG2N) : l_q;
    byp_eff  = start ? cfg_bypass : byp_q;
    last_eff = (int'(k_eff) == ((1 << l_eff) - 1));
    k_nxt    = last_eff ? '0 : k_eff + MAX_LOG2N'(1);
    j_eff    = MAX_LOG2N'(mirror_idx(int'(k_eff), int'(l_eff), MAX_LOG2N));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      l_q   <= 4'(MAX_LOG2N);
      byp_q <= 1'b0;
    end else if (acc) begin
      k_q <= k_nxt;
      if (start) begin
        l_q   <= l_eff;
        byp_q <= byp_eff;
      end
    end else if (frame_rst) begin
      k_q <= '0;
    end
  end

  hann_coef_ram #(
    .AW(MAX_LOG2N), .DW(COEF_W), .DEPTH(TBL_D), .INIT_FILE(INIT_FILE)
  ) u_ram (
    .clk    (clk),
    .wr_en  (coef_wr_en),
    .wr_addr(coef_wr_addr),
    .wr_data(coef_wr_data),
    .rd_en  (adv),
    .rd_addr(s1_j),
    .rd_data(coef)
  );

  always_comb begin
    prod   = PW'($signed(s2_data)) * PW'($signed({1'b0, coef}));
    prod_r = prod + RND;
    wdata  = DATA_W'(prod_r >>> COEF_W);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_j     <= '0;
      s1_last  <= 1'b0;
      s1_byp   <= 1'b0;
      s2_data  <= '0;
      s2_last  <= 1'b0;
      s2_byp   <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else if (adv) begin
      vld_pipe <= {vld_pipe[STAGES-1:0], acc};
      s1_data  <= s_data;
      s1_j     <= j_eff;
      s1_last  <= last_eff & acc;
      s1_byp   <= byp_eff;
      s2_data  <= s1_data;
      s2_last  <= s1_last & vld_pipe[0];
      s2_byp   <= s1_byp;
      m_data   <= s2_byp ? s2_data : wdata;
      m_last   <= s2_last & vld_pipe[1];
    end
  end

endmodule
